// File: rtl/mips_pkg.sv
// Shared encodings for the memory access unit: sizes, FSM state, lane masks.
// Helpers derive byte enables, store-lane replication and misalignment.
package mips_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   localparam logic [3:0] BE_BYTE    = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   function automatic logic [3:0] lane_en(
      input logic [1:0] size,
      input logic [1:0] off
   );
      unique case (1'b1)
         (size == SZ_BYTE): lane_en = BE_BYTE << off;
         (size == SZ_HALF): lane_en = off[1] ? BE_HALF_HI : BE_HALF_LO;
         default:           lane_en = BE_WORD;
      endcase
   endfunction

   function automatic logic [31:0] rep_data(
      input logic [1:0]  size,
      input logic [31:0] d
   );
      unique case (1'b1)
         (size == SZ_BYTE): rep_data = {4{d[7:0]}};
         (size == SZ_HALF): rep_data = {2{d[15:0]}};
         default:           rep_data = d;
      endcase
   endfunction

   // Encoding 00 is a word access, so it misaligns like 11.
   function automatic logic is_misaligned(
      input logic [1:0] size,
      input logic [1:0] off
   );
      unique case (1'b1)
         (size == SZ_BYTE): is_misaligned = 1'b0;
         (size == SZ_HALF): is_misaligned = off[0];
         default:           is_misaligned = |off;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the loaded lane out of the bus word and sign/zero extends it.
// Half and word offsets are truncated to their natural alignment.
module load_extend
   import mips_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = rdata[{off, 3'b000} +: 8];
      h = rdata[{off[1], 4'b0000} +: 16];
      unique case (1'b1)
         (size == SZ_BYTE):
            data = {{24{sign & b[7]}}, b};
         (size == SZ_HALF):
            data = {{16{sign & h[15]}}, h};
         default:
            data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus master: IDLE -> ACCESS -> DONE with timeout error.
// MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of truncating.
module mem_access_unit
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemDataSize,
   input  logic        MemDataSign,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic        Stall,
   output logic [31:0] ReadData,
   output logic        BusReq,
   output logic        BusWe,
   output logic [31:0] BusAddr,
   output logic [3:0]  BusByteEn,
   output logic [31:0] BusWData,
   input  logic        BusAck,
   input  logic [31:0] BusRData,
   output logic        BusErr,
   output logic        Misaligned
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_t          state;
   state_t          nstate;
   logic [CW-1:0]   cnt;
   logic            req;
   logic            trap;
   logic            start;
   logic            ack_ok;
   logic            tmo;
   logic [1:0]      size_q;
   logic [1:0]      off_q;
   logic            sign_q;
   logic [31:0]     ext;

   assign req = MemRead | MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap = (state == IDLE) & req
               & is_misaligned(MemDataSize, Addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   assign start  = (state == IDLE) & req & ~trap;
   assign ack_ok = (state == ACCESS) & BusAck;
   assign tmo    = (state == ACCESS) & ~BusAck
                 & (cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    nstate = trap  ? DONE
                         : start ? ACCESS : IDLE;
         ACCESS:  nstate = (ack_ok | tmo) ? DONE : ACCESS;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      BusReq = (state == ACCESS);
      Stall  = start | (state == ACCESS);
   end

   load_extend u_ext (
      .rdata (BusRData),
      .off   (off_q),
      .size  (size_q),
      .sign  (sign_q),
      .data  (ext)
   );

   // Bus fields are captured once and held steady for the whole access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         BusWe     <= 1'b0;
         BusAddr   <= '0;
         BusByteEn <= '0;
         BusWData  <= '0;
         size_q    <= '0;
         off_q     <= '0;
         sign_q    <= 1'b0;
         cnt       <= '0;
         ReadData  <= '0;
         BusErr    <= 1'b0;
      end else begin
         BusErr <= tmo;
         if (start) begin
            BusWe     <= MemWrite;
            BusAddr   <= {Addr[31:2], 2'b00};
            BusByteEn <= lane_en(MemDataSize, Addr[1:0]);
            BusWData  <= rep_data(MemDataSize, WriteData);
            size_q    <= MemDataSize;
            off_q     <= Addr[1:0];
            sign_q    <= MemDataSign;
         end
         if (state == ACCESS) cnt <= cnt + 1'b1;
         else                 cnt <= '0;
         if (ack_ok && !BusWe)  ReadData <= ext;
         else if (tmo || trap)  ReadData <= '0;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) Misaligned <= 1'b0;
      else        Misaligned <= trap;
   end
`else
   assign Misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised and directed bench for mem_access_unit (TIMEOUT_CYCLES = 4)
// against a byte-arithmetic reference model.
module tb_mem_access_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead, MemWrite, MemDataSign;
   logic [1:0]  MemDataSize;
   logic [31:0] Addr, WriteData;
   logic        Stall;
   logic [31:0] ReadData;
   logic        BusReq, BusWe;
   logic [31:0] BusAddr;
   logic [3:0]  BusByteEn;
   logic [31:0] BusWData;
   logic        BusAck;
   logic [31:0] BusRData;
   logic        BusErr, Misaligned;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemDataSize (MemDataSize),
      .MemDataSign (MemDataSign),
      .Addr        (Addr),
      .WriteData   (WriteData),
      .Stall       (Stall),
      .ReadData    (ReadData),
      .BusReq      (BusReq),
      .BusWe       (BusWe),
      .BusAddr     (BusAddr),
      .BusByteEn   (BusByteEn),
      .BusWData    (BusWData),
      .BusAck      (BusAck),
      .BusRData    (BusRData),
      .BusErr      (BusErr),
      .Misaligned  (Misaligned)
   );

   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] exp_rd;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      if (sz == 2'b01)      return 1;
      else if (sz == 2'b10) return 2;
      else                  return 4;
   endfunction

   function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
      int nb = nbytes(sz);
      return ((a % 4) / nb) * nb;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      int v = ((1 << nbytes(sz)) - 1) << lane_off(sz, a);
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] r;
      int nb = nbytes(sz);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz,
                                          input bit sg, input logic [31:0] a);
      int          bits = 8 * nbytes(sz);
      logic [31:0] mask = (bits == 32) ? 32'hFFFF_FFFF : (32'h1 << bits) - 1;
      logic [31:0] v = (rd >> (8 * lane_off(sz, a))) & mask;
      if (sg && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
      int nb = nbytes(sz);
      return (nb == 2 && (a % 2) != 0) || (nb == 4 && (a % 4) != 0);
`else
      return (sz == 2'b10) && (a === 32'hx);
`endif
   endfunction

   // One request; ack_at = ACCESS cycle index carrying BusAck, <0 or >=TMO: none.
   task automatic access(input bit rd, input bit wr, input logic [1:0] sz,
                         input bit sg, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int ack_at);
      bit mis = m_mis(sz, a);
      bit ok  = (ack_at >= 0) && (ack_at < TMO);
      int stalls = 0;
      int n = 0;
      bit fin = 0;
      @(negedge clk);
      MemRead = rd; MemWrite = wr; MemDataSize = sz;
      MemDataSign = sg; Addr = a; WriteData = wd;
      #1;
      chk("stall_req", Stall, !mis);
      chk("busreq_idle", BusReq, 0);
      stalls += Stall;
      @(negedge clk);
      MemRead = 0; MemWrite = 0;
      if (mis) begin
         exp_rd = 0;
         chk("mis_pulse", Misaligned, 1);
         chk("mis_noreq", BusReq, 0);
         chk("mis_stall", Stall, 0);
         chk("mis_rd", ReadData, exp_rd);
         @(negedge clk);
         chk("mis_clear", Misaligned, 0);
         chk("mis_noreq2", BusReq, 0);
         return;
      end
      while (!fin) begin
         chk("busreq", BusReq, 1);
         chk("stall_acc", Stall, 1);
         chk("busaddr", BusAddr, a & 32'hFFFF_FFFC);
         chk("byteen", BusByteEn, m_be(sz, a));
         chk("wdata", BusWData, m_wd(sz, wd));
         chk("buswe", BusWe, wr);
         stalls += Stall;
         BusAck = (n == ack_at);
         BusRData = BusAck ? rdat : $urandom;
         @(negedge clk);
         BusAck = 0;
         n++;
         if ((ok && n - 1 == ack_at) || n == TMO) fin = 1;
      end
      if (ok && !wr) exp_rd = m_load(rdat, sz, sg, a);
      if (!ok) exp_rd = 0;
      chk("done_busreq", BusReq, 0);
      chk("done_stall", Stall, 0);
      chk("done_buserr", BusErr, !ok);
      chk("done_mis", Misaligned, 0);
      chk("done_rdata", ReadData, exp_rd);
      chk("stall_cycles", stalls, 1 + n);
      @(negedge clk);
      chk("buserr_clear", BusErr, 0);
      chk("rdata_hold", ReadData, exp_rd);
   endtask

   initial begin
      rst_n = 0; MemRead = 0; MemWrite = 0; MemDataSize = 0; MemDataSign = 0;
      Addr = 0; WriteData = 0; BusAck = 0; BusRData = 0;
      exp_rd = 0;
      #2;
      chk("rst_busreq", BusReq, 0);
      chk("rst_busaddr", BusAddr, 0);
      chk("rst_byteen", BusByteEn, 0);
      chk("rst_wdata", BusWData, 0);
      chk("rst_rdata", ReadData, 0);
      chk("rst_stall", Stall, 0);
      chk("rst_err", BusErr, 0);
      chk("rst_mis", Misaligned, 0);
      @(negedge clk);
      rst_n = 1;

      access(1, 0, 2'b11, 0, 32'h100, 0, 32'hDEADBEEF, 0);
      chk("lw_value", ReadData, 32'hDEADBEEF);
      access(1, 0, 2'b01, 1, 32'h103, 0, 32'h80FF_0000, 1);
      chk("lb_value", ReadData, 32'hFFFF_FF80);
      access(1, 0, 2'b01, 0, 32'h103, 0, 32'h80FF_0000, 0);
      chk("lbu_value", ReadData, 32'h0000_0080);
      access(0, 1, 2'b10, 0, 32'h202, 32'h1234ABCD, 0, 0);
      access(1, 0, 2'b11, 0, 32'h300, 0, 0, -1);
      chk("tmo_value", ReadData, 0);
      access(1, 1, 2'b11, 0, 32'h400, 32'hCAFEF00D, 0, 2);
      access(1, 0, 2'b11, 0, 32'h101, 0, 32'h11223344, 0);

      // Stray acknowledge while idle must be ignored.
      @(negedge clk);
      BusAck = 1; BusRData = $urandom;
      @(negedge clk);
      BusAck = 0;
      chk("stray_busreq", BusReq, 0);
      chk("stray_stall", Stall, 0);
      chk("stray_rdata", ReadData, exp_rd);

      // Reset in the middle of an access.
      @(negedge clk);
      MemRead = 1; MemDataSize = 2'b11; Addr = 32'h500;
      @(negedge clk);
      MemRead = 0;
      chk("mid_busreq", BusReq, 1);
      rst_n = 0;
      #1;
      exp_rd = 0;
      chk("mid_rst_busreq", BusReq, 0);
      chk("mid_rst_addr", BusAddr, 0);
      chk("mid_rst_be", BusByteEn, 0);
      chk("mid_rst_rdata", ReadData, 0);
      chk("mid_rst_stall", Stall, 0);
      @(negedge clk);
      rst_n = 1;
      access(1, 0, 2'b11, 0, 32'h104, 0, 32'h0BADF00D, 0);

      for (int i = 0; i < 40; i++) begin
         bit rd, wr;
         int sel = $urandom_range(0, 2);
         rd = (sel != 1);
         wr = (sel != 0);
         access(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, $urandom_range(0, 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of ACCESS cycles allowed without BusAck before an error completion.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port MemRead, input, 1, load request from the decoder.
REQ-005 SHALL have port MemWrite, input, 1, store request from the decoder.
REQ-006 SHALL have port MemDataSize, input, 2, access size: 11 word, 10 half, 01 byte, 00 treated as word.
REQ-007 SHALL have port MemDataSign, input, 1, load data is sign-extended when 1 and zero-extended when 0.
REQ-008 SHALL have port Addr, input, 32, byte address from the ALU.
REQ-009 SHALL have port WriteData, input, 32, store data, with the value in the low bits.
REQ-010 SHALL have port Stall, output, 1, which holds the pipeline while an access is in progress.
REQ-011 SHALL have port ReadData, output, 32, extended load result.
REQ-012 SHALL have port BusReq, output, 1, memory request.
REQ-013 SHALL have port BusWe, output, 1, memory write enable.
REQ-014 SHALL have port BusAddr, output, 32, word-aligned address with bits [1:0] equal to 0.
REQ-015 SHALL have port BusByteEn, output, 4, active byte lanes, little-endian.
REQ-016 SHALL have port BusWData, output, 32, lane-replicated store data.
REQ-017 SHALL have port BusAck, input, 1, memory completion.
REQ-018 SHALL have port BusRData, input, 32, memory read word, valid with BusAck.
REQ-019 SHALL have port BusErr, output, 1, one-cycle timeout pulse.
REQ-020 SHALL have port Misaligned, output, 1, one-cycle misalignment pulse.

Function
REQ-021 SHALL implement a FSM with states IDLE, ACCESS and DONE.
REQ-022 SHALL capture Addr, size, sign, WriteData and the read/write request on the IDLE to ACCESS transition, which occurs when MemRead or MemWrite is 1.
REQ-023 SHALL treat MemRead and MemWrite both 1 as a write.
REQ-024 SHALL hold Stall = 1 in IDLE while a request is present and no trap fires, and throughout ACCESS; Stall = 0 in DONE and in idle IDLE.
REQ-025 SHALL assert BusReq continuously in ACCESS, with BusAddr, BusWe, BusByteEn and BusWData stable, until BusAck is sampled high; the FSM then goes to DONE.
REQ-026 SHALL drive BusByteEn as follows: byte 0001 shifted left by Addr[1:0]; half 0011 when Addr[1] = 0, else 1100; word 1111.
REQ-027 SHALL drive BusWData as byte replicated 4 times, half replicated twice, or the full word.
REQ-028 SHALL register the loaded lane of BusRData at BusAck and extend it per the captured sign; ReadData holds that value from DONE until the next completion.
REQ-029 SHALL return minimum latency of 2 cycles, from request to DONE, when BusAck arrives in the first ACCESS cycle.
REQ-030 SHALL count ACCESS cycles; on reaching TIMEOUT_CYCLES without BusAck, it SHALL drop BusReq, go to DONE, pulse BusErr for 1 cycle and set ReadData to 0.
REQ-031 SHALL return from DONE to IDLE unconditionally after 1 cycle, so that a new request is accepted in the following cycle.
REQ-032 SHALL ignore a BusAck that is asserted outside ACCESS.

Reset
REQ-033 SHALL, on rst_n = 0 and at any point including mid-access, immediately set state IDLE, BusReq 0, BusWe 0, BusByteEn 0, BusAddr 0, BusWData 0, ReadData 0, BusErr 0, Misaligned 0, and the counter 0; Stall is then 0 unless a request is present.

Configuration
REQ-034 SHALL support macro MEM_MISALIGN_TRAP_EN.
REQ-035 SHALL, when MEM_MISALIGN_TRAP_EN is defined, detect a half access with Addr[0] = 1 or a word access with Addr[1:0] != 0 and respond as follows: no bus transaction; go directly to DONE; pulse Misaligned for 1 cycle; ReadData 0.
REQ-036 SHALL, when MEM_MISALIGN_TRAP_EN is undefined, tie Misaligned to 0 and ignore the low address bits that cause misalignment, with lane selection using truncated alignment.

Structure
REQ-037 SHALL place the MemDataSize encodings, the FSM state typedef, and the byte-enable constants in shared package mips_pkg.
REQ-038 SHALL place lane select and sign/zero extension in one combinational sub-module named load_extend.

Verification
REQ-039 SHALL verify that LW at Addr 0x100 with BusAck in the first ACCESS cycle and BusRData 0xDEADBEEF gives BusByteEn 1111, ReadData 0xDEADBEEF, and Stall high for exactly 2 cycles.
REQ-040 SHALL verify that LB at Addr 0x103 with BusRData 0x80FF_0000 gives BusByteEn 1000 and ReadData 0xFFFFFF80; LBU gives ReadData 0x00000080.
REQ-041 SHALL verify that SH at Addr 0x202 with WriteData 0x1234ABCD gives BusByteEn 1100, BusWData 0xABCDABCD, BusAddr 0x200 and BusWe 1.
REQ-042 SHALL verify that with no BusAck and TIMEOUT_CYCLES = 4, BusReq drops after 4 cycles, BusErr pulses for 1 cycle and ReadData is 0.
REQ-043 SHALL verify that rst_n asserted during ACCESS deasserts BusReq the same cycle and that the following LW completes normally.
REQ-044 SHALL verify that with MEM_MISALIGN_TRAP_EN defined, LW at 0x101 produces a Misaligned pulse and no BusReq; without the macro, the same access reads at BusAddr 0x100.
